// File: rtl/spi_pkg.sv
// Shared definitions for the simple_spi master: register map, bit positions,
// transfer-engine states and the SCK divider lookup.
package spi_pkg;

  localparam logic [2:0] ADR_SPCR = 3'd0;
  localparam logic [2:0] ADR_SPSR = 3'd1;
  localparam logic [2:0] ADR_SPDR = 3'd2;
  localparam logic [2:0] ADR_SPER = 3'd3;
  localparam logic [2:0] ADR_SSR  = 3'd4;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 4;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;

  localparam int SPSR_SPIF    = 7;
  localparam int SPSR_WCOL    = 6;
  localparam int SPSR_WFFULL  = 3;
  localparam int SPSR_WFEMPTY = 2;
  localparam int SPSR_RFFULL  = 1;
  localparam int SPSR_RFEMPTY = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PHASE1 = 2'd1,
    ST_PHASE2 = 2'd2
  } eng_state_e;

  // Half SCK period minus one, in clk cycles, for the {ESPR,SPR} selector.
  function automatic logic [10:0] half_period_m1(input logic [3:0] sel);
    logic [10:0] v;
    case (sel)
      4'd0:    v = 11'd0;
      4'd1:    v = 11'd1;
      4'd2:    v = 11'd7;
      4'd3:    v = 11'd15;
      4'd4:    v = 11'd3;
      4'd5:    v = 11'd31;
      4'd6:    v = 11'd63;
      4'd7:    v = 11'd127;
      4'd8:    v = 11'd255;
      4'd9:    v = 11'd511;
      4'd10:   v = 11'd1023;
      default: v = 11'd2047;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fifo4.sv
// 8-bit, 4-entry synchronous FIFO. Overflowing pushes and underflowing pops
// are ignored; an empty FIFO keeps presenting the last byte popped.
module fifo4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;
  logic [7:0] r_last;
  logic       w_do_push;
  logic       w_do_pop;

  assign full      = (r_cnt == 3'd4);
  assign empty     = (r_cnt == 3'd0);
  assign w_do_push = push & ~full & ~clr;
  assign w_do_pop  = pop & ~empty & ~clr;
  assign dout      = empty ? r_last : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= 2'd0;
      r_rp   <= 2'd0;
      r_cnt  <= 3'd0;
      r_last <= 8'h00;
    end else if (clr) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 2'd1;
      if (w_do_pop) begin
        r_rp   <= r_rp + 2'd1;
        r_last <= r_mem[r_rp];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/simple_spi.sv
// SPI master with an 8-bit Wishbone classic register interface, 4-deep
// transmit/receive FIFOs, CPOL/CPHA modes and a byte-count interrupt.
module simple_spi
  import spi_pkg::*;
#(
  parameter int SS_WIDTH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [2:0]          adr_i,
  input  logic [7:0]          dat_i,
  output logic [7:0]          dat_o,
  output logic                ack_o,
  output logic                inta_o,
  output logic                sck_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic [SS_WIDTH-1:0] ss_o,
  output logic [1:0]          dbg_state_o
);

  // Wishbone handshake: a request is cyc_i&stb_i; ack_o rises the cycle after
  // and stays for exactly one cycle. Writes, FIFO pushes and pops commit on the
  // edge that ends the ack cycle; dat_o is loaded when the request is first
  // seen and held while ack_o is high.
  logic w_wb_req;
  logic w_wb_commit;
  logic w_wr;
  logic w_rd;
  logic w_wr_spcr;
  logic w_wr_spsr;
  logic w_wr_spdr;
  logic w_wr_sper;
  logic w_wr_ssr;
  logic w_rd_spdr;

  assign w_wb_req    = cyc_i & stb_i;
  assign w_wb_commit = w_wb_req & ack_o;
  assign w_wr        = w_wb_commit & we_i;
  assign w_rd        = w_wb_commit & ~we_i;
  assign w_wr_spcr   = w_wr & (adr_i == ADR_SPCR);
  assign w_wr_spsr   = w_wr & (adr_i == ADR_SPSR);
  assign w_wr_spdr   = w_wr & (adr_i == ADR_SPDR);
  assign w_wr_sper   = w_wr & (adr_i == ADR_SPER);
  assign w_wr_ssr    = w_wr & (adr_i == ADR_SSR);
  assign w_rd_spdr   = w_rd & (adr_i == ADR_SPDR);

  logic                r_spie;
  logic                r_spe;
  logic                r_cpol;
  logic                r_cpha;
  logic [1:0]          r_spr;
  logic [1:0]          r_icnt;
  logic [1:0]          r_espr;
  logic [SS_WIDTH-1:0] r_ssr;
  logic                r_spif;
  logic                r_wcol;
  logic [1:0]          r_tcnt;

  logic       w_wf_full;
  logic       w_wf_empty;
  logic [7:0] w_wf_dout;
  logic       w_wf_pop;
  logic       w_rf_full;
  logic       w_rf_empty;
  logic [7:0] w_rf_dout;
  logic       w_fifo_clr;
  logic       r_rf_push;
  logic [7:0] r_rf_din;

  // Disabling the core through SPCR flushes both FIFOs; while SPE stays low
  // software may still preload the transmit FIFO.
  assign w_fifo_clr = w_wr_spcr & ~dat_i[SPCR_SPE];

  fifo4 u_wfifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (w_wr_spdr),
    .pop   (w_wf_pop),
    .clr   (w_fifo_clr),
    .din   (dat_i),
    .dout  (w_wf_dout),
    .full  (w_wf_full),
    .empty (w_wf_empty)
  );

  fifo4 u_rfifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (r_rf_push),
    .pop   (w_rd_spdr),
    .clr   (w_fifo_clr),
    .din   (r_rf_din),
    .dout  (w_rf_dout),
    .full  (w_rf_full),
    .empty (w_rf_empty)
  );

  logic [7:0] w_ssr_rd;
  logic [7:0] w_rd_data;

  always_comb begin
    w_ssr_rd = 8'h00;
    w_ssr_rd[SS_WIDTH-1:0] = r_ssr;
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (adr_i)
      ADR_SPCR: w_rd_data = {r_spie, r_spe, 1'b0, 1'b1, r_cpol, r_cpha, r_spr};
      ADR_SPSR: w_rd_data = {r_spif, r_wcol, 2'b00,
                             w_wf_full, w_wf_empty, w_rf_full, w_rf_empty};
      ADR_SPDR: w_rd_data = w_rf_dout;
      ADR_SPER: w_rd_data = {r_icnt, 4'b0000, r_espr};
      ADR_SSR:  w_rd_data = w_ssr_rd;
      default:  w_rd_data = 8'h00;
    endcase
  end

  logic w_cnt_hit;
  assign w_cnt_hit = r_rf_push & (r_tcnt == r_icnt);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= 8'h00;
      inta_o <= 1'b0;
      r_spie <= 1'b0;
      r_spe  <= 1'b0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_spr  <= 2'd0;
      r_icnt <= 2'd0;
      r_espr <= 2'd0;
      r_ssr  <= '0;
      r_spif <= 1'b0;
      r_wcol <= 1'b0;
      r_tcnt <= 2'd0;
    end else begin
      ack_o  <= w_wb_req & ~ack_o;
      inta_o <= r_spif & r_spie;
      if (w_wb_req & ~ack_o) dat_o <= w_rd_data;

      if (w_wr_spcr) begin
        r_spie <= dat_i[SPCR_SPIE];
        r_spe  <= dat_i[SPCR_SPE];
        r_cpol <= dat_i[SPCR_CPOL];
        r_cpha <= dat_i[SPCR_CPHA];
        r_spr  <= dat_i[1:0];
      end
      if (w_wr_sper) begin
        r_icnt <= dat_i[7:6];
        r_espr <= dat_i[1:0];
      end
      if (w_wr_ssr) r_ssr <= dat_i[SS_WIDTH-1:0];

      // A completion in the same cycle as a software clear wins.
      if (w_wr_spsr & dat_i[SPSR_SPIF]) r_spif <= 1'b0;
      if (w_cnt_hit) r_spif <= 1'b1;
      if (w_wr_spsr & dat_i[SPSR_WCOL]) r_wcol <= 1'b0;
      if (w_wr_spdr & w_wf_full) r_wcol <= 1'b1;

      if (w_wr_spcr | w_wr_sper) r_tcnt <= 2'd0;
      else if (w_cnt_hit)        r_tcnt <= 2'd0;
      else if (r_rf_push)        r_tcnt <= r_tcnt + 2'd1;
    end
  end

  eng_state_e  r_state;
  logic        r_sck;
  logic        r_mosi;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [2:0]  r_bit_cnt;
  logic [10:0] r_div_cnt;
  logic [10:0] w_half;
  logic [7:0]  w_rx_next;

  assign w_half    = half_period_m1({r_espr, r_spr});
  assign w_wf_pop  = r_spe & (r_state == ST_IDLE) & ~w_wf_empty;
  assign w_rx_next = r_cpha ? {r_rx[6:0], miso_i} : r_rx;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_div_cnt <= 11'd0;
      r_rf_push <= 1'b0;
      r_rf_din  <= 8'h00;
    end else begin
      r_rf_push <= 1'b0;
      if (!r_spe) begin
        r_state <= ST_IDLE;
        r_sck   <= r_cpol;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sck <= r_cpol;
            if (w_wf_pop) begin
              r_tx      <= w_wf_dout;
              r_bit_cnt <= 3'd7;
              r_div_cnt <= w_half;
              r_state   <= ST_PHASE1;
              if (!r_cpha) r_mosi <= w_wf_dout[7];
            end
          end
          ST_PHASE1: begin
            if (r_div_cnt == 11'd0) begin
              r_div_cnt <= w_half;
              r_sck     <= ~r_cpol;
              r_state   <= ST_PHASE2;
              if (!r_cpha) begin
                r_rx <= {r_rx[6:0], miso_i};
              end else begin
                r_mosi <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
            end else begin
              r_div_cnt <= r_div_cnt - 11'd1;
            end
          end
          ST_PHASE2: begin
            if (r_div_cnt == 11'd0) begin
              r_div_cnt <= w_half;
              r_sck     <= r_cpol;
              r_rx      <= w_rx_next;
              if (!r_cpha) begin
                r_mosi <= r_tx[6];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
              if (r_bit_cnt == 3'd0) begin
                r_state   <= ST_IDLE;
                r_rf_push <= 1'b1;
                r_rf_din  <= w_rx_next;
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
                r_state   <= ST_PHASE1;
              end
            end else begin
              r_div_cnt <= r_div_cnt - 11'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sck_o       = r_sck;
  assign mosi_o      = r_mosi;
  assign ss_o        = ~r_ssr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_simple_spi.sv
// Directed self-checking bench for simple_spi: register reset values, loopback
// transfers, FIFO overflow, byte-count interrupt, CPOL=1 timing, slave select
// and mid-byte abort.
interface wishbone_if (input logic clk_i);
  logic       rst_i;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [2:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       inta_o;
endinterface

interface spi_if;
  logic sck_o;
  logic mosi_o;
  logic miso_i;
endinterface

module tb_simple_spi;
  import spi_pkg::*;

  logic       clk;
  logic [0:0] ss_o;
  logic [1:0] dbg_state;
  logic       loop_en;
  logic       drv_miso;
  int         n_checks;
  int         n_fail;

  wishbone_if wb (.clk_i(clk));
  spi_if      spi ();

  assign spi.miso_i = loop_en ? spi.mosi_o : drv_miso;

  simple_spi #(.SS_WIDTH(1)) dut (
    .clk_i       (clk),
    .rst_i       (wb.rst_i),
    .cyc_i       (wb.cyc_i),
    .stb_i       (wb.stb_i),
    .we_i        (wb.we_i),
    .adr_i       (wb.adr_i),
    .dat_i       (wb.dat_i),
    .dat_o       (wb.dat_o),
    .ack_o       (wb.ack_o),
    .inta_o      (wb.inta_o),
    .sck_o       (spi.sck_o),
    .mosi_o      (spi.mosi_o),
    .miso_i      (spi.miso_i),
    .ss_o        (ss_o),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic wb_access(input logic we, input logic [2:0] a, input logic [7:0] d,
                           output logic [7:0] rd);
    int n;
    @(posedge clk); #1;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.adr_i = a; wb.dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.ack_o && n < 8);
    rd = wb.dat_o;
    n_checks++;
    if (wb.ack_o !== 1'b1 || n != 1) begin
      n_fail++;
      $display("FAIL wb_ack adr=%0d: ack_o=%b after %0d cycles, required 1 after 1", a, wb.ack_o, n);
    end
    @(posedge clk); #1;
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    wb_access(1'b1, a, d, unused_rd);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] rd);
    wb_access(1'b0, a, 8'h00, rd);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [7:0] rd;
    wb.rst_i = 1'b0; wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    wb.adr_i = 3'd0; wb.dat_i = 8'h00;
    loop_en = 1'b1; drv_miso = 1'b0;
    wait_clks(3);
    n_checks++;
    if ({wb.ack_o, wb.inta_o, spi.sck_o, spi.mosi_o, ss_o} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_outputs: ack,inta,sck,mosi,ss=%b required 00001",
               {wb.ack_o, wb.inta_o, spi.sck_o, spi.mosi_o, ss_o});
    end
    n_checks++;
    if (wb.dat_o !== 8'h00 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dat_state: dat_o=%h state=%0d required 00 / 0", wb.dat_o, dbg_state);
    end
    wb.rst_i = 1'b1;
    wait_clks(1);
    wb_read(ADR_SPCR, rd);
    n_checks++;
    if (rd !== 8'h10) begin n_fail++; $display("FAIL reset_spcr: got %h required 10", rd); end
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL reset_spsr: got %h required 05", rd); end
    wb_read(ADR_SPER, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_sper: got %h required 00", rd); end
    wb_read(ADR_SSR, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_ssr: got %h required 00", rd); end
    // MSTR stays 1 and the reserved bit stays 0; unmapped addresses read 0.
    wb_write(ADR_SPCR, 8'h20);
    wb_read(ADR_SPCR, rd);
    n_checks++;
    if (rd !== 8'h10) begin n_fail++; $display("FAIL spcr_fixed_bits: got %h required 10", rd); end
    wb_write(3'd5, 8'hFF);
    wb_read(3'd5, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL unmapped_adr5: got %h required 00", rd); end
  endtask

  task automatic test_loopback();
    logic [7:0] rd;
    logic       prev;
    int         toggles, first, last;
    loop_en = 1'b1;
    wb_write(ADR_SPCR, 8'h50);
    wb_write(ADR_SPDR, 8'hA5);
    prev = spi.sck_o; toggles = 0; first = -1; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (spi.sck_o !== prev) begin
        toggles++;
        if (first < 0) first = i;
        last = i;
        prev = spi.sck_o;
      end
    end
    n_checks++;
    if (toggles != 16 || (last - first) != 15) begin
      n_fail++;
      $display("FAIL loop_sck_toggles: %0d toggles over span %0d, required 16 over 15", toggles, last - first);
    end
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h84) begin n_fail++; $display("FAIL loop_spsr: got %h required 84", rd); end
    wb_read(ADR_SPDR, rd);
    n_checks++;
    if (rd !== 8'hA5) begin n_fail++; $display("FAIL loop_spdr: got %h required a5", rd); end
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h85) begin n_fail++; $display("FAIL loop_spsr_drained: got %h required 85", rd); end
    wb_write(ADR_SPSR, 8'h80);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL loop_spif_clear: got %h required 05", rd); end
  endtask

  task automatic test_wcol();
    logic [7:0] rd;
    wb_write(ADR_SPCR, 8'h10);
    for (int i = 0; i < 3; i++) wb_write(ADR_SPDR, 8'(i + 1));
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h01) begin n_fail++; $display("FAIL wf_three: got %h required 01", rd); end
    wb_write(ADR_SPDR, 8'h04);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h09) begin n_fail++; $display("FAIL wf_full: got %h required 09", rd); end
    wb_write(ADR_SPDR, 8'h05);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h49) begin n_fail++; $display("FAIL wcol_set: got %h required 49", rd); end
    wb_write(ADR_SPSR, 8'h40);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h09) begin n_fail++; $display("FAIL wcol_clear: got %h required 09", rd); end
    wb_write(ADR_SPCR, 8'h10);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL fifo_flush: got %h required 05", rd); end
  endtask

  task automatic test_icnt();
    logic [7:0] rd;
    logic [7:0] exp_sr;
    logic [7:0] pat [0:3];
    pat = '{8'h11, 8'h5A, 8'hC3, 8'hFF};
    loop_en = 1'b1;
    wb_write(ADR_SPER, 8'hC0);
    wb_write(ADR_SPCR, 8'hD0);
    for (int k = 0; k < 4; k++) begin
      wb_write(ADR_SPDR, pat[k]);
      wait_clks(30);
      exp_sr = (k == 3) ? 8'h86 : 8'h04;
      wb_read(ADR_SPSR, rd);
      n_checks++;
      if (rd !== exp_sr || wb.inta_o !== (k == 3)) begin
        n_fail++;
        $display("FAIL icnt_byte%0d: spsr=%h inta=%b required %h / %b", k, rd, wb.inta_o, exp_sr, k == 3);
      end
    end
    for (int k = 0; k < 4; k++) begin
      wb_read(ADR_SPDR, rd);
      n_checks++;
      if (rd !== pat[k]) begin n_fail++; $display("FAIL icnt_data%0d: got %h required %h", k, rd, pat[k]); end
    end
    wb_write(ADR_SPSR, 8'h80);
    wait_clks(2);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05 || wb.inta_o !== 1'b0) begin
      n_fail++;
      $display("FAIL icnt_clear: spsr=%h inta=%b required 05 / 0", rd, wb.inta_o);
    end
  endtask

  task automatic test_cpol();
    logic [7:0] rd;
    logic [7:0] slave_tx;
    logic [7:0] slave_rx;
    logic       prev;
    int         edges, idx;
    longint     t0, t1;
    wb_write(ADR_SPER, 8'h00);
    wb_write(ADR_SPCR, 8'h5B);
    wait_clks(2);
    n_checks++;
    if (spi.sck_o !== 1'b1) begin n_fail++; $display("FAIL cpol_idle: sck=%b required 1", spi.sck_o); end
    loop_en = 1'b0;
    slave_tx = 8'h3C; slave_rx = 8'h00;
    drv_miso = slave_tx[7];
    idx = 0; edges = 0; t0 = 0; t1 = 0;
    wb_write(ADR_SPDR, 8'h96);
    prev = spi.sck_o;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (spi.sck_o !== prev) begin
        prev = spi.sck_o;
        if (edges == 0) t0 = $time;
        if (edges == 1) t1 = $time;
        edges++;
        if (spi.sck_o == 1'b0) begin
          slave_rx = {slave_rx[6:0], spi.mosi_o};
        end else begin
          idx++;
          if (idx < 8) drv_miso = slave_tx[7 - idx];
        end
      end
    end
    n_checks++;
    if (edges != 16 || (t1 - t0) != 160) begin
      n_fail++;
      $display("FAIL cpol_timing: %0d edges, half period %0d, required 16 / 160", edges, t1 - t0);
    end
    n_checks++;
    if (slave_rx !== 8'h96 || spi.sck_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cpol_mosi: slave saw %h sck=%b required 96 / 1", slave_rx, spi.sck_o);
    end
    wb_read(ADR_SPDR, rd);
    n_checks++;
    if (rd !== 8'h3C) begin n_fail++; $display("FAIL cpol_miso: got %h required 3c", rd); end
    wb_write(ADR_SPSR, 8'h80);
  endtask

  task automatic test_ss_abort();
    logic [7:0] rd;
    wb_write(ADR_SSR, 8'h01);
    n_checks++;
    if (ss_o !== 1'b0) begin n_fail++; $display("FAIL ss_assert: ss_o=%b required 0", ss_o); end
    wb_write(ADR_SPDR, 8'hF0);
    wb_write(ADR_SPDR, 8'h0F);
    wait_clks(40);
    n_checks++;
    if (dbg_state === 2'd0) begin n_fail++; $display("FAIL abort_busy: state=%0d required nonzero", dbg_state); end
    wb_write(ADR_SPCR, 8'h18);
    wait_clks(1);
    n_checks++;
    if (spi.sck_o !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_idle: sck=%b state=%0d required 1 / 0", spi.sck_o, dbg_state);
    end
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL abort_fifos: got %h required 05", rd); end
    wait_clks(300);
    wb_read(ADR_SPSR, rd);
    n_checks++;
    if (rd !== 8'h05 || ss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_late_byte: spsr=%h ss=%b required 05 / 0", rd, ss_o);
    end
    wb_write(ADR_SSR, 8'h00);
    n_checks++;
    if (ss_o !== 1'b1) begin n_fail++; $display("FAIL ss_release: ss_o=%b required 1", ss_o); end
  endtask

  // Sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_loopback();
    test_wcol();
    test_icnt();
    test_cpol();
    test_ss_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_spi.md
# simple_spi

SPI master core with an 8-bit Wishbone B3 classic slave register interface, modelled on the Motorola M68HC11 SPI. It sits between a Wishbone bus and an off-chip SPI slave: software writes bytes into a 4-deep transmit FIFO and reads received bytes from a 4-deep receive FIFO. It provides programmable SCK divider, CPOL/CPHA modes, transfer-count interrupt and software-driven slave selects.

## Interface
- SS_WIDTH, default 1: number of slave-select outputs.
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe, write enable.
- adr_i  in  3  register address.
- dat_i  in  8  write data.
- dat_o  out  8  registered read data.
- ack_o  out  1  Wishbone acknowledge.
- inta_o  out  1  interrupt, active-high, registered.
- sck_o  out  1  SPI serial clock.
- mosi_o  out  1  SPI master-out data.
- miso_i  in  1  SPI master-in data.
- ss_o  out  SS_WIDTH  slave selects, active-low.

## Operation
- Register map (adr_i):
  - 0 SPCR: [7] SPIE, [6] SPE, [5] reserved (reads 0), [4] MSTR (reads 1, not writable), [3] CPOL, [2] CPHA, [1:0] SPR. Reset value 0x10.
  - 1 SPSR: [7] SPIF, [6] WCOL, [5:4] reads 0, [3] WFFULL, [2] WFEMPTY, [1] RFFULL, [0] RFEMPTY.
    - Writing 1 to bit 7 clears SPIF; writing 1 to bit 6 clears WCOL.
    - Reset value 0x05.
  - 2 SPDR: a write pushes to the write FIFO; a read pops from the read FIFO.
  - 3 SPER: [7:6] ICNT, [1:0] ESPR, other bits read 0. Reset value 0x00.
  - 4 SSR: [SS_WIDTH-1:0]. ss_o = ~SSR. Reset value 0, so ss_o resets to all ones.
  - Addresses 5-7 read 0, and writes to them are ignored.
- SCK divide ratio is selected by {ESPR,SPR}:
  - 0→2, 1→4, 2→16, 3→32, 4→8, 5→64, 6→128, 7→256.
  - 8→512, 9→1024, 10→2048, 11→4096.
  - 12-15 behave as 4096.
- Write FIFO behaviour:
  - A write to SPDR while the write FIFO is full sets WCOL, and the byte is discarded.
  - A received byte arriving while the read FIFO is full is discarded.
  - Popping an empty FIFO returns the last output value and has no side effect.
- SPE=0 holds the transfer engine idle and clears both FIFOs. sck_o then rests at CPOL.
- Transfer engine:
  - When SPE=1, the engine is idle and the write FIFO is non-empty, it pops one byte and shifts 8 bits MSB-first.
  - CPHA=0: mosi_o is valid before the first SCK edge, MISO is sampled on the leading edge, and MOSI changes on the trailing edge.
  - CPHA=1: MOSI changes on the leading edge, and MISO is sampled on the trailing edge.
  - The idle level of sck_o is CPOL.
  - When 8 bits are done, the received byte is pushed into the read FIFO.
- The transfer counter increments per completed byte. When it equals ICNT (0→1 byte, 1→2, 2→3, 3→4 bytes), SPIF is set and the counter resets. Writing SPCR or SPER resets the counter.
- inta_o = SPIF & SPIE.
- Engine states:
  - IDLE → PHASE1 on a non-empty write FIFO with SPE=1.
  - PHASE1 → PHASE2 after half an SCK period.
  - PHASE2 → PHASE1 for the next bit, or → IDLE after bit 8.
  - SPE cleared mid-transfer → IDLE immediately; the partial byte is lost.

## Timing
- ack_o asserts one cycle after cyc_i&stb_i and lasts 1 cycle (ack_o = cyc&stb&~ack_o, registered). Back-to-back accesses therefore take 2 cycles each.
- Register writes and FIFO push/pop take effect on the ack cycle. dat_o is valid while ack_o is high.
- Each SCK half-period lasts divide/2 clk_i cycles. One byte takes 8×divide clk cycles plus 1 cycle to start from IDLE.
- Status bits update the cycle after the causing event. inta_o lags SPIF by 1 cycle.
- Outputs in reset:
  - ack_o=0, inta_o=0, dat_o=0.
  - sck_o=0 (CPOL reset is 0), mosi_o=0, ss_o all ones.
  - FIFOs empty, engine in IDLE.

## Structure
- Package spi_pkg holds:
  - register address constants (SPCR=0, SPSR=1, SPDR=2, SPER=3, SSR=4);
  - SPCR/SPSR bit-index constants;
  - the engine state enum.
- One sub-module, fifo4: an 8-bit, 4-entry FIFO with ports push, pop, clr, din, dout, full, empty. It is instantiated twice, once as the write FIFO and once as the read FIFO.
- Interfaces wishbone_if (clock, rst_i, bus signals) and spi_if (sck_o, mosi_o, miso_i) bundle the bench connections.

## Test plan
- Reset → SPCR reads 0x10, SPSR 0x05, SPER 0x00, SSR 0x00, ss_o=1, inta_o=0.
- MOSI looped to MISO, SPCR=0x50 (mode 0, divide 2), write 0xA5:
  - → sck toggles 16 times over 16 clk;
  - → SPSR shows RFEMPTY=0 and SPIF=1;
  - → SPDR reads 0xA5.
- Write 5 bytes with SPE=0 → after the 4th write, WFFULL=1; after the 5th, WCOL=1. Writing 0x40 to SPSR clears WCOL.
- SPER ICNT=3, SPIE=1, 4 bytes transferred → SPIF and inta_o set only after the 4th byte. Writing 0x80 to SPSR clears both.
- SPCR=0x5B (CPOL=1, CPHA=0, SPR=3), ESPR=0 → sck idles high with a half-period of 16 clk. Miso driven with 0x3C → read back 0x3C.
- Write 1 to SSR → ss_o=0. Clearing SPE mid-byte → sck returns to CPOL and both FIFOs are empty.
